// File: rtl/mpc_cfg_pkg.sv
// Shared types and constants for the pad-mux configuration controller.
package mpc_cfg_pkg;

  // Blank/settle counter must hold any duration in 1..255.
  localparam int unsigned CNT_W = $clog2(256);

  typedef logic [3:0] cfg_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/mpc_cfg_timer.sv
// Down-counter timing the blank and settle intervals.
module mpc_cfg_timer
  import mpc_cfg_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load on state entry, otherwise count down and rest at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // The count reaches zero at the coming edge, so a load of N yields exactly N cycles.
  always_comb zero_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// Pad-mux configuration controller: blanks pad OEs around a configuration switch.
// Optional feature: define MPC_CFG_LOCK_EN to add the cfg_lock input and lock flag.
module mpc_cfg_ctrl
  import mpc_cfg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter cfg_code_t   DEFAULT_CFG   = 4'h0,
  parameter logic [15:0] LEGAL_MASK    = 16'hFFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cfg_req_valid,
  input  logic [3:0] cfg_req_data,
`ifdef MPC_CFG_LOCK_EN
  input  logic       cfg_lock,
`endif
  output logic       cfg_req_ready,
  output logic [3:0] configuration,
  output logic       oe_blank,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [7:0] change_count
);

  state_e    state_q, state_d;
  cfg_code_t cfg_q, cfg_d;
  cfg_code_t pend_q, pend_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic accept, legal, start, enter_settle, finish, locked, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

`ifdef MPC_CFG_LOCK_EN
  logic lock_q, lock_d;

  // Lock flag: set by cfg_lock sampled in IDLE, cleared only by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q | ((state_q == ST_IDLE) & cfg_lock);
    locked = lock_q;
  end
`else
  always_comb locked = 1'b0;
`endif

  // Request decode; busy_q distinguishes a user switch from the post-reset sequence.
  always_comb begin
    accept       = (state_q == ST_IDLE) & cfg_req_valid;
    legal        = LEGAL_MASK[cfg_req_data] & ~locked;
    start        = accept & legal & (cfg_req_data != cfg_q);
    enter_settle = (state_q == ST_BLANK) & tmr_zero;
    finish       = (state_q == ST_SETTLE) & tmr_zero;
    tmr_load_val = start ? CNT_W'(BLANK_CYCLES) : CNT_W'(SETTLE_CYCLES);
  end

  mpc_cfg_timer #(
    .RST_VAL(CNT_W'(BLANK_CYCLES))
  ) u_timer (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (start | enter_settle),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_BLANK;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start)        state_d = ST_BLANK;
      ST_BLANK:  if (enter_settle) state_d = ST_SETTLE;
      ST_SETTLE: if (finish)       state_d = ST_IDLE;
      default:                     state_d = ST_BLANK;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cfg_req_ready = (state_q == ST_IDLE);
    oe_blank      = (state_q != ST_IDLE);
  end

  // Datapath next-state: pending code, applied code, status and change counter.
  always_comb begin
    pend_d = start ? cfg_req_data : pend_q;
    cfg_d  = (enter_settle & busy_q) ? pend_q : cfg_q;
    busy_d = start | (busy_q & ~finish);
    done_d = (accept & ~start) | (finish & busy_q);
    err_d  = err_q | (accept & ~legal);
    cnt_d  = cnt_q;
    if (enter_settle && busy_q && (cnt_q != '1)) cnt_d = cnt_q + 8'd1;
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cfg_q  <= DEFAULT_CFG;
      pend_q <= DEFAULT_CFG;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cfg_q  <= cfg_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    configuration = cfg_q;
    cfg_done      = done_q;
    cfg_err       = err_q;
    change_count  = cnt_q;
  end

endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// Self-checking bench for mpc_cfg_ctrl (B=4, S=2, DEFAULT_CFG=0).
// A second instance uses LEGAL_MASK=16'h000F for the illegal-code case.
module tb_mpc_cfg_ctrl;

  localparam int B = 4;
  localparam int S = 2;

  typedef struct {
    logic [3:0] cfg;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] data = 4'h0;
  logic       lock = 1'b0;
  logic       ready, oe, done, err;
  logic [3:0] cfg;
  logic [7:0] cnt;

  logic       m_valid = 1'b0;
  logic [3:0] m_data = 4'h0;
  logic       m_ready, m_oe, m_done, m_err;
  logic [3:0] m_cfg;
  logic [7:0] m_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t       sb_q[$];
  logic [3:0] exp_cfg = 4'h0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  logic       lock_exp = 1'b0;
  logic [15:0] main_mask = 16'hFFFF;

  always #5 clk = ~clk;

  mpc_cfg_ctrl #(
    .BLANK_CYCLES(B), .SETTLE_CYCLES(S), .DEFAULT_CFG(4'h0), .LEGAL_MASK(16'hFFFF)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_req_valid(valid), .cfg_req_data(data),
`ifdef MPC_CFG_LOCK_EN
    .cfg_lock(lock),
`endif
    .cfg_req_ready(ready), .configuration(cfg), .oe_blank(oe),
    .cfg_done(done), .cfg_err(err), .change_count(cnt)
  );

  mpc_cfg_ctrl #(
    .BLANK_CYCLES(B), .SETTLE_CYCLES(S), .DEFAULT_CFG(4'h0), .LEGAL_MASK(16'h000F)
  ) u_dut_m (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_req_valid(m_valid), .cfg_req_data(m_data),
`ifdef MPC_CFG_LOCK_EN
    .cfg_lock(1'b0),
`endif
    .cfg_req_ready(m_ready), .configuration(m_cfg), .oe_blank(m_oe),
    .cfg_done(m_done), .cfg_err(m_err), .change_count(m_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each completion pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_cfg", 32'(cfg), 32'(e.cfg));
        chk("sb_err", 32'(err), 32'(e.err));
        chk("sb_cnt", 32'(cnt), 32'(e.cnt));
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_oe",   32'(oe),    32'(1));
    chk("rst_rdy",  32'(ready), 32'(0));
    chk("rst_done", 32'(done),  32'(0));
    chk("rst_err",  32'(err),   32'(0));
    chk("rst_cnt",  32'(cnt),   32'(0));
    chk("rst_cfg",  32'(cfg),   32'(0));
  endtask

  task automatic release_check();
    rst = 1'b0;
    for (int i = 0; i < B + S; i++) begin
      chk("rel_oe",   32'(oe),    32'(1));
      chk("rel_rdy",  32'(ready), 32'(0));
      chk("rel_done", 32'(done),  32'(0));
      chk("m_rel_oe", 32'(m_oe),  32'(1));
      @(negedge clk);
    end
    chk("idle_oe",   32'(oe),    32'(0));
    chk("idle_rdy",  32'(ready), 32'(1));
    chk("idle_cfg",  32'(cfg),   32'(0));
    chk("idle_cnt",  32'(cnt),   32'(0));
    chk("idle_done", 32'(done),  32'(0));
  endtask

  task automatic do_req(input logic [3:0] code, input bit detail, input bit noise);
    logic [3:0] old_cfg;
    logic [7:0] old_cnt;
    bit lgl, chg;
    int wait_n;
    wait_n = 0;
    while (ready !== 1'b1 && wait_n < 64) begin
      @(negedge clk);
      wait_n++;
    end
    if (ready !== 1'b1) begin
      chk("ready_timeout", 32'(0), 32'(1));
      return;
    end
    lgl = main_mask[code] && !lock_exp;
    chg = lgl && (code != exp_cfg);
    old_cfg = exp_cfg;
    old_cnt = exp_cnt;
    if (!lgl) exp_err = 1'b1;
    if (chg) begin
      exp_cfg = code;
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
    end
    sb_q.push_back('{cfg: exp_cfg, err: exp_err, cnt: exp_cnt});
    valid = 1'b1;
    data  = code;
    @(negedge clk);
    valid = 1'b0;
    if (!chg) begin
      if (detail) begin
        chk("imm_done", 32'(done),  32'(1));
        chk("imm_oe",   32'(oe),    32'(0));
        chk("imm_rdy",  32'(ready), 32'(1));
        chk("imm_cfg",  32'(cfg),   32'(old_cfg));
        chk("imm_cnt",  32'(cnt),   32'(old_cnt));
      end
      @(negedge clk);
      if (detail) chk("imm_pulse", 32'(done), 32'(0));
    end else begin
      for (int k = 1; k <= B + S + 1; k++) begin
        if (noise) begin
          valid = (k < B + S);
          data  = ~code;
        end
        if (detail) begin
          chk("seq_oe",   32'(oe),    32'(k <= B + S));
          chk("seq_cfg",  32'(cfg),   32'((k <= B) ? old_cfg : code));
          chk("seq_cnt",  32'(cnt),   32'((k <= B) ? old_cnt : exp_cnt));
          chk("seq_done", 32'(done),  32'(k == B + S + 1));
          chk("seq_rdy",  32'(ready), 32'(k == B + S + 1));
        end
        if (k < B + S + 1) @(negedge clk);
      end
      valid = 1'b0;
      @(negedge clk);
      if (detail) chk("seq_pulse", 32'(done), 32'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    release_check();

    // Legal change with requests held during blank/settle, then same-code request.
    do_req(4'h5, 1'b1, 1'b1);
    do_req(4'h5, 1'b1, 1'b0);
    do_req(4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      do_req(4'($urandom_range(0, 15)), 1'b1, 1'($urandom_range(0, 1)));

    // Illegal code on the restricted-mask instance.
    m_valid = 1'b1;
    m_data  = 4'h9;
    @(negedge clk);
    m_valid = 1'b0;
    chk("m_err",  32'(m_err),  32'(1));
    chk("m_done", 32'(m_done), 32'(1));
    chk("m_cfg",  32'(m_cfg),  32'(0));
    chk("m_oe",   32'(m_oe),   32'(0));
    chk("m_rdy",  32'(m_ready), 32'(1));
    @(negedge clk);
    chk("m_done_pulse", 32'(m_done), 32'(0));
    chk("m_err_sticky", 32'(m_err),  32'(1));
    m_valid = 1'b1;
    m_data  = 4'h2;
    @(negedge clk);
    m_valid = 1'b0;
    chk("m_legal_oe", 32'(m_oe), 32'(1));
    repeat (B + S) @(negedge clk);
    chk("m_legal_done", 32'(m_done), 32'(1));
    chk("m_legal_cfg",  32'(m_cfg),  32'(2));
    chk("m_legal_cnt",  32'(m_cnt),  32'(1));
    chk("m_legal_err",  32'(m_err),  32'(1));

    // Saturation of change_count.
    for (int i = 0; i < 260; i++)
      do_req((i % 2 == 0) ? 4'h1 : 4'h2, 1'b0, 1'b0);
    chk("sat_cnt", 32'(cnt), 32'(255));

    // Reset in the middle of a switch to 4'hA.
    while (ready !== 1'b1) @(negedge clk);
    valid = 1'b1;
    data  = 4'hA;
    @(negedge clk);
    valid = 1'b0;
    chk("mid_oe", 32'(oe), 32'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    exp_cfg = 4'h0;
    exp_err = 1'b0;
    exp_cnt = 8'd0;
    check_reset_vals();
    release_check();
    do_req(4'h6, 1'b1, 1'b0);

`ifdef MPC_CFG_LOCK_EN
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    lock_exp = 1'b1;
    do_req(4'h3, 1'b1, 1'b0);
    chk("lock_err", 32'(err), 32'(1));
    chk("lock_cfg", 32'(cfg), 32'(6));
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpc_cfg_ctrl.md
MPC_CFG_CTRL -- requirements
Module: mpc_cfg_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 4, number of cycles all pad OEs are forced off before a configuration switch; legal range 1..255.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, number of cycles OEs stay forced off after the new configuration is applied; legal range 1..255.
REQ-003 SHALL have parameter DEFAULT_CFG, default 4'h0, configuration value loaded at reset.
REQ-004 SHALL have parameter LEGAL_MASK, default 16'hFFFF, where bit n set means configuration code n is legal.
REQ-005 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 wb_rst_i  input  1  synchronous, active-high reset.
REQ-007 cfg_req_valid  input  1  a configuration change request is present.
REQ-008 cfg_req_data  input  4  requested configuration code.
REQ-009 cfg_req_ready  output  1  controller can accept a request this cycle.
REQ-010 configuration  output  4  code driven to the pad multiplexer.
REQ-011 oe_blank  output  1  when high, the integration level forces every pad OE to 0.
REQ-012 cfg_done  output  1  one-cycle pulse when an accepted request completes.
REQ-013 cfg_err  output  1  sticky; set on a rejected request; cleared only by reset.
REQ-014 change_count  output  8  saturating count of applied configuration changes.

Function
REQ-015 SHALL implement states IDLE, BLANK, SETTLE; cfg_req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted in the cycle T in which cfg_req_valid and cfg_req_ready are both 1; cfg_req_data is sampled at T only.
REQ-017 Legal, different code: cycles T+1..T+B SHALL be BLANK with oe_blank=1 and configuration unchanged; cycles T+B+1..T+B+S SHALL be SETTLE with configuration equal to the new code and oe_blank=1; in cycle T+B+S+1 the controller SHALL return to IDLE with oe_blank=0 and cfg_done=1. (B=BLANK_CYCLES, S=SETTLE_CYCLES.)
REQ-018 Legal code equal to the current configuration: the controller SHALL stay in IDLE, SHALL NOT blank, SHALL NOT increment change_count, and SHALL pulse cfg_done in T+1.
REQ-019 Illegal code (LEGAL_MASK bit clear): the controller SHALL stay in IDLE with configuration unchanged, SHALL set cfg_err in T+1, and SHALL pulse cfg_done in T+1.
REQ-020 change_count SHALL increment on entry to SETTLE for accepted requests only, and SHALL saturate at 255.
REQ-021 cfg_req_valid outside IDLE SHALL be ignored, with no queueing; the requester SHALL hold valid until ready is 1.
REQ-022 The blank/settle duration SHALL come from a single down-counter loaded on each state entry; the counter width is the minimum able to hold 255.

Reset
REQ-023 While wb_rst_i=1, the controller SHALL drive state=BLANK, counter loaded with BLANK_CYCLES, configuration=DEFAULT_CFG, oe_blank=1, cfg_req_ready=0, cfg_done=0, cfg_err=0, change_count=0.
REQ-024 After reset release, the controller SHALL run the BLANK then SETTLE sequence (B+S cycles, oe_blank=1) before entering IDLE; no cfg_done SHALL be produced and change_count SHALL NOT be incremented.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence and discard the pending code, with no cfg_done.

Configuration
REQ-026 Macro MPC_CFG_LOCK_EN: when defined, the block SHALL add input cfg_lock (1 bit); cfg_lock=1 sampled in IDLE SHALL set a lock flag, cleared only by reset; while the flag is set, accepted requests SHALL be treated as illegal (REQ-019).
REQ-027 When MPC_CFG_LOCK_EN is not defined, the cfg_lock port and the lock flag SHALL be absent, and behaviour SHALL be as in REQ-015..REQ-025.

Structure
REQ-028 Shared package mpc_cfg_pkg SHALL hold the state enum, the 4-bit config code typedef and the counter-width constant.
REQ-029 The down-counter SHALL be the sub-module mpc_cfg_timer, with load, load value and zero-flag outputs.

Verification (B=4, S=2, DEFAULT_CFG=0)
REQ-030 Reset release -> oe_blank=1 for 6 cycles, then ready=1, configuration=0, change_count=0, no cfg_done.
REQ-031 Request 4'h5 accepted at T -> configuration=0 through T+4, =5 from T+5, oe_blank=0 and cfg_done=1 at T+7, change_count=1.
REQ-032 LEGAL_MASK=16'h000F, request 4'h9 -> cfg_err=1 and cfg_done=1 at T+1, configuration unchanged, no blanking.
REQ-033 Request equal to current code 4'h5 -> cfg_done at T+1, oe_blank stays 0, change_count unchanged.
REQ-034 wb_rst_i pulsed at T+3 of a 4'hA request -> configuration=0, full reset blank sequence, no cfg_done.
REQ-035 MPC_CFG_LOCK_EN defined, cfg_lock=1 in IDLE, then request 4'h3 -> cfg_err=1, configuration unchanged.
